// File: rtl/parc_core_rob_pkg.sv
// Shared definitions for the PARC core reorder buffer.
// Provides the default geometry, the slot and entry types, and the modulo
// age comparison that the ROB squash logic and the scoreboard both use.
package parc_core_rob_pkg;

  localparam int unsigned ROB_ENTRIES = 16;
  localparam int unsigned ROB_SLOT_W  = 4;
  localparam int unsigned ROB_REG_W   = 5;
  localparam int unsigned ROB_DATA_W  = 32;

  typedef logic [ROB_SLOT_W-1:0] rob_slot_t;

  typedef struct packed {
    logic                  valid;
    logic                  filled;
    logic [ROB_REG_W-1:0]  dst;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

  // True when 'slot' is strictly younger than 'ref_slot'.
  // Age is the modulo distance from the head, so the result holds across wrap.
  function automatic logic rob_younger(input rob_slot_t slot,
                                       input rob_slot_t ref_slot,
                                       input rob_slot_t head);
    rob_slot_t age_slot;
    rob_slot_t age_ref;
    age_slot = slot - head;
    age_ref  = ref_slot - head;
    return age_slot > age_ref;
  endfunction

endpackage

// File: rtl/parc_core_rob_ctrl_if.sv
// ROB control bus between decode/writeback/branch logic and the ROB.
// master : decode/writeback side (drives alloc, fill and squash requests)
// slave  : ROB side (drives alloc grant, commit port and occupancy)
interface parc_core_rob_ctrl_if #(
  parameter int unsigned SLOT_W = 4,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DATA_W = 32
);
  logic              rob_alloc_req;
  logic [REG_W-1:0]  rob_alloc_dst;
  logic              rob_alloc_rdy;
  logic [SLOT_W-1:0] rob_alloc_slot;
  logic              rob_fill_val;
  logic [SLOT_W-1:0] rob_fill_slot;
  logic [DATA_W-1:0] rob_fill_data;
  logic              rob_squash_val;
  logic [SLOT_W-1:0] rob_squash_slot;
  logic              rob_commit_wen;
  logic [SLOT_W-1:0] rob_commit_slot;
  logic [REG_W-1:0]  rob_commit_waddr;
  logic [DATA_W-1:0] rob_commit_data;
  logic [SLOT_W:0]   rob_count;

  modport master (
    output rob_alloc_req, rob_alloc_dst,
    output rob_fill_val, rob_fill_slot, rob_fill_data,
    output rob_squash_val, rob_squash_slot,
    input  rob_alloc_rdy, rob_alloc_slot,
    input  rob_commit_wen, rob_commit_slot, rob_commit_waddr, rob_commit_data,
    input  rob_count
  );

  modport slave (
    input  rob_alloc_req, rob_alloc_dst,
    input  rob_fill_val, rob_fill_slot, rob_fill_data,
    input  rob_squash_val, rob_squash_slot,
    output rob_alloc_rdy, rob_alloc_slot,
    output rob_commit_wen, rob_commit_slot, rob_commit_waddr, rob_commit_data,
    output rob_count
  );
endinterface

// File: rtl/parc_core_rob_entry_array.sv
// Per-entry ROB storage: valid/filled flags (reset) and dst/data (not reset).
// Ports: alloc write (alloc_*), fill write (fill_*), invalidate mask
// (inval_mask_i, commit and squash), asynchronous head read (head_*),
// and the full valid vector (valid_o).
module parc_core_rob_entry_array #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned SLOT_W  = 4,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_en_i,
  input  logic [SLOT_W-1:0]  alloc_slot_i,
  input  logic [REG_W-1:0]   alloc_dst_i,
  input  logic               fill_en_i,
  input  logic [SLOT_W-1:0]  fill_slot_i,
  input  logic [DATA_W-1:0]  fill_data_i,
  input  logic [ENTRIES-1:0] inval_mask_i,
  input  logic [SLOT_W-1:0]  head_slot_i,
  output logic [ENTRIES-1:0] valid_o,
  output logic               head_valid_o,
  output logic               head_filled_o,
  output logic [REG_W-1:0]   head_dst_o,
  output logic [DATA_W-1:0]  head_data_o
);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] filled_q;
  logic [REG_W-1:0]   dst_q  [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic               fill_ok;

  // Fills to empty slots, or slots being squashed this cycle, are dropped.
  assign fill_ok = fill_en_i && valid_q[fill_slot_i] && !inval_mask_i[fill_slot_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      filled_q <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (inval_mask_i[i]) valid_q[i] <= 1'b0;
        if (alloc_en_i && alloc_slot_i == SLOT_W'(i)) begin
          valid_q[i]  <= 1'b1;
          filled_q[i] <= 1'b0;
        end
        if (fill_ok && fill_slot_i == SLOT_W'(i)) filled_q[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en_i) dst_q[alloc_slot_i] <= alloc_dst_i;
    if (fill_ok)    data_q[fill_slot_i] <= fill_data_i;
  end

  assign valid_o       = valid_q;
  assign head_valid_o  = valid_q[head_slot_i];
  assign head_filled_o = filled_q[head_slot_i];
  assign head_dst_o    = dst_q[head_slot_i];
  assign head_data_o   = data_q[head_slot_i];

endmodule

// File: rtl/parc_core_rob_ctrl.sv
// In-order reorder-buffer controller for the 5-stage PARC core.
// Ports: clk, reset_n (async active-low), rob (slave side of the ROB bus:
// alloc request/grant, writeback fill, squash, commit port, occupancy).
module parc_core_rob_ctrl
  import parc_core_rob_pkg::*;
#(
  parameter int unsigned ENTRIES = ROB_ENTRIES,
  parameter int unsigned SLOT_W  = ROB_SLOT_W,
  parameter int unsigned REG_W   = ROB_REG_W,
  parameter int unsigned DATA_W  = ROB_DATA_W
) (
  input logic                 clk,
  input logic                 reset_n,
  parc_core_rob_ctrl_if.slave rob
);

  localparam logic [SLOT_W:0] CNT_FULL = (SLOT_W+1)'(ENTRIES);

  logic [SLOT_W-1:0]  head_q, head_d;
  logic [SLOT_W-1:0]  tail_q, tail_d;
  logic [SLOT_W:0]    count_q, count_d;
  logic [ENTRIES-1:0] inval_mask;
  logic [ENTRIES-1:0] valid_vec;
  logic               head_valid, head_filled;
  logic               alloc_rdy, alloc_fire, commit_fire;
  logic [SLOT_W:0]    survivors;

  assign alloc_rdy   = (count_q != CNT_FULL) && !rob.rob_squash_val;
  assign alloc_fire  = rob.rob_alloc_req && alloc_rdy;
  assign commit_fire = head_valid && head_filled;

  // Squash keeps head..squash_slot inclusive. Counting survivors from the
  // pre-commit head and then subtracting the commit keeps a full-survivor
  // squash at ENTRIES instead of aliasing to 0 through the modulo difference.
  assign survivors = {1'b0, SLOT_W'(rob.rob_squash_slot - head_q)} + (SLOT_W+1)'(1);

  always_comb begin
    head_d     = head_q + SLOT_W'(commit_fire);
    tail_d     = tail_q;
    count_d    = count_q;
    inval_mask = '0;
    if (commit_fire) inval_mask[head_q] = 1'b1;
    if (rob.rob_squash_val) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (rob_younger(rob_slot_t'(i), rob.rob_squash_slot, head_q))
          inval_mask[i] = 1'b1;
      end
      tail_d  = rob.rob_squash_slot + SLOT_W'(1);
      count_d = survivors - (SLOT_W+1)'(commit_fire);
    end else begin
      tail_d  = tail_q + SLOT_W'(alloc_fire);
      count_d = count_q + (SLOT_W+1)'(alloc_fire) - (SLOT_W+1)'(commit_fire);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  parc_core_rob_entry_array #(
    .ENTRIES (ENTRIES),
    .SLOT_W  (SLOT_W),
    .REG_W   (REG_W),
    .DATA_W  (DATA_W)
  ) u_entries (
    .clk           (clk),
    .rst_n         (reset_n),
    .alloc_en_i    (alloc_fire),
    .alloc_slot_i  (tail_q),
    .alloc_dst_i   (rob.rob_alloc_dst),
    .fill_en_i     (rob.rob_fill_val),
    .fill_slot_i   (rob.rob_fill_slot),
    .fill_data_i   (rob.rob_fill_data),
    .inval_mask_i  (inval_mask),
    .head_slot_i   (head_q),
    .valid_o       (valid_vec),
    .head_valid_o  (head_valid),
    .head_filled_o (head_filled),
    .head_dst_o    (rob.rob_commit_waddr),
    .head_data_o   (rob.rob_commit_data)
  );

  assign rob.rob_alloc_rdy   = alloc_rdy;
  assign rob.rob_alloc_slot  = tail_q;
  assign rob.rob_commit_wen  = commit_fire;
  assign rob.rob_commit_slot = head_q;
  assign rob.rob_count       = count_q;

`ifndef SYNTHESIS
  a_count_pop: assert property (@(posedge clk) disable iff (!reset_n)
    count_q == (SLOT_W+1)'($countones(valid_vec)));
  a_squash_valid: assert property (@(posedge clk) disable iff (!reset_n)
    rob.rob_squash_val |-> valid_vec[rob.rob_squash_slot]);
`endif

endmodule
